// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  localparam int DEPTH          = 64;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    BYTES = 3'd2,
    CLEAR = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } loader_state_t;

  // A word count is usable only if it names at least one word and fits the memory.
  function automatic logic legal_count(input logic [7:0] count, input int depth);
    return (count != 8'd0) && (int'(count) <= depth);
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles little-endian stream bytes into 32-bit words; the first byte of a
// word lands in [7:0] and word_valid pulses alongside the fourth byte.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  byte_cnt;
  logic [23:0] low_bytes;

  // The three earlier bytes shift down so the fourth can be appended on top.
  always_ff @(posedge clk) begin
    if (!reset) begin
      byte_cnt  <= 2'd0;
      low_bytes <= 24'd0;
    end else if (clear) begin
      byte_cnt  <= 2'd0;
      low_bytes <= 24'd0;
    end else if (accept) begin
      byte_cnt  <= byte_cnt + 2'd1;
      low_bytes <= {data, low_bytes[23:8]};
    end
  end

  assign word_valid = accept && (byte_cnt == 2'(BYTES_PER_WORD - 1));
  assign word       = {data, low_bytes};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a word count and program bytes, writes the words from
// address 0, zero-fills the rest of instruction memory, then releases the CPU.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int N      = 32,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [N-1:0]      wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = ADDR_W + 1;

  loader_state_t    state, next_state;
  logic             accept;
  logic             load_go;
  logic             count_ok;
  logic             pack_accept;
  logic             word_valid;
  logic [N-1:0]     word;
  logic             last_word;
  logic             clear_active;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] clr_cnt;

  assign accept       = byte_valid && byte_ready;
  assign load_go      = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
  assign count_ok     = legal_count(byte_data, DEPTH);
  assign pack_accept  = accept && (state == BYTES);
  assign last_word    = word_valid && (word_cnt == (w_count - CNT_W'(1)));
  assign clear_active = (state == CLEAR) && (clr_cnt != CNT_W'(DEPTH));

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (load_go),
    .accept     (pack_accept),
    .data       (byte_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    byte_ready = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = COUNT;
      end
      COUNT: begin
        byte_ready = 1'b1;
        if (accept) next_state = count_ok ? BYTES : ERROR;
      end
      BYTES: begin
        byte_ready = 1'b1;
        if (last_word) next_state = CLEAR;
      end
      CLEAR: begin
        if (!clear_active) next_state = DONE;
      end
      DONE, ERROR: begin
        if (start) next_state = COUNT;
      end
      default: next_state = IDLE;
    endcase
  end

  // The clear counter picks up at the word count so zero-fill continues where the image ends.
  always_ff @(posedge clk) begin
    if (!reset) begin
      w_count  <= '0;
      word_cnt <= '0;
      clr_cnt  <= '0;
    end else begin
      if (load_go)            word_cnt <= '0;
      else if (word_valid)    word_cnt <= word_cnt + CNT_W'(1);

      if ((state == COUNT) && accept && count_ok)
        w_count <= byte_data[CNT_W-1:0];

      if (last_word)          clr_cnt <= w_count;
      else if (clear_active)  clr_cnt <= clr_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      wr_en <= word_valid || clear_active;
      if (word_valid) begin
        wr_addr <= word_cnt[ADDR_W-1:0];
        wr_data <= word;
      end else if (clear_active) begin
        wr_addr <= clr_cnt[ADDR_W-1:0];
        wr_data <= '0;
      end
      cpu_hold <= (next_state != DONE);
      done     <= (next_state == DONE);
      err      <= (next_state == ERROR);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: logs every memory write and checks addresses,
// data and handshake timing against hand-computed program images.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_acc = 0;

  logic [31:0] prog_words [64];
  logic [5:0]  log_addr [$];
  logic [31:0] log_data [$];
  int          log_cyc  [$];

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
      log_cyc.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic with_start);
    int guard = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    start      = with_start;
    while (byte_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) checkOutput("byte_ready_timeout", 32'(byte_ready), 32'd1);
    @(negedge clk);
    last_acc   = cyc - 1;
    byte_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic run_load(input int w, input bit gap, input bit busy, input string tag);
    int   base;
    int   acc;
    int   guard = 0;
    logic prev_hold;
    logic [31:0] want;
    base = log_addr.size();
    pulse_start();
    checkOutput({tag, " ready_in_count"}, 32'(byte_ready), 32'd1);
    checkOutput({tag, " hold_in_count"}, 32'(cpu_hold), 32'd1);
    checkOutput({tag, " done_in_count"}, 32'(done), 32'd0);
    send_byte(8'(w), 1'b0);
    for (int k = 0; k < w; k++) begin
      for (int b = 0; b < 4; b++) begin
        send_byte(prog_words[k][8*b +: 8], busy && (k == 0) && (b == 2));
        if (gap && !((k == w - 1) && (b == 3))) @(negedge clk);
      end
    end
    acc = last_acc;
    if (busy) begin
      repeat (5) @(negedge clk);
      pulse_start();
    end
    prev_hold = cpu_hold;
    while (done !== 1'b1 && guard < 300) begin
      prev_hold = cpu_hold;
      @(negedge clk);
      guard++;
    end
    checkOutput({tag, " done_cycle"}, 32'(cyc), 32'(acc + 2 + 64 - w));
    checkOutput({tag, " hold_released"}, 32'(cpu_hold), 32'd0);
    checkOutput({tag, " hold_before_done"}, 32'(prev_hold), 32'd1);
    checkOutput({tag, " write_count"}, 32'(log_addr.size() - base), 32'd64);
    for (int i = 0; i < 64; i++) begin
      if (base + i < log_addr.size()) begin
        want = (i < w) ? prog_words[i] : 32'h0;
        checkOutput($sformatf("%s addr[%0d]", tag, i), 32'(log_addr[base+i]), 32'(i));
        checkOutput($sformatf("%s data[%0d]", tag, i), log_data[base+i], want);
      end
    end
    if (base + w - 1 < log_cyc.size())
      checkOutput({tag, " last_word_cycle"}, 32'(log_cyc[base+w-1]), 32'(acc + 1));
    if (w < 64 && base + w < log_cyc.size())
      checkOutput({tag, " first_zero_cycle"}, 32'(log_cyc[base+w]), 32'(acc + 2));
  endtask

  task automatic set_two_word();
    prog_words[0] = 32'hf8000001;
    prog_words[1] = 32'hf8008002;
  endtask

  task automatic applyStimulus();
    int base;
    logic [7:0] kb;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst byte_ready", 32'(byte_ready), 32'd0);
    checkOutput("rst wr_en", 32'(wr_en), 32'd0);
    checkOutput("rst wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("rst wr_data", wr_data, 32'd0);
    checkOutput("rst cpu_hold", 32'(cpu_hold), 32'd1);
    checkOutput("rst done", 32'(done), 32'd0);
    checkOutput("rst err", 32'(err), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle byte_ready", 32'(byte_ready), 32'd0);

    set_two_word();
    run_load(2, 1'b0, 1'b0, "two_word");
    @(negedge clk);
    checkOutput("done_held", 32'(done), 32'd1);

    for (int k = 0; k < 64; k++) begin
      kb = 8'(k);
      prog_words[k] = {~kb, 8'hA5, kb + 8'h10, kb};
    end
    run_load(64, 1'b0, 1'b0, "full");

    base = log_addr.size();
    pulse_start();
    checkOutput("ill0 ready", 32'(byte_ready), 32'd1);
    send_byte(8'd0, 1'b0);
    checkOutput("ill0 err", 32'(err), 32'd1);
    checkOutput("ill0 hold", 32'(cpu_hold), 32'd1);
    checkOutput("ill0 ready_low", 32'(byte_ready), 32'd0);
    checkOutput("ill0 done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("ill0 no_writes", 32'(log_addr.size() - base), 32'd0);
    pulse_start();
    checkOutput("ill65 err_cleared", 32'(err), 32'd0);
    checkOutput("ill65 ready", 32'(byte_ready), 32'd1);
    send_byte(8'd65, 1'b0);
    checkOutput("ill65 err", 32'(err), 32'd1);
    checkOutput("ill65 hold", 32'(cpu_hold), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("ill65 no_writes", 32'(log_addr.size() - base), 32'd0);

    prog_words[0] = 32'h12345678;
    run_load(1, 1'b0, 1'b0, "recover");

    set_two_word();
    run_load(2, 1'b1, 1'b0, "gap");
    run_load(2, 1'b0, 1'b1, "busy");

    base = log_addr.size();
    pulse_start();
    send_byte(8'd3, 1'b0);
    for (int b = 0; b < 4; b++) send_byte(prog_words[0][8*b +: 8], 1'b0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checkOutput("midrst byte_ready", 32'(byte_ready), 32'd0);
    checkOutput("midrst wr_en", 32'(wr_en), 32'd0);
    checkOutput("midrst wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("midrst wr_data", wr_data, 32'd0);
    checkOutput("midrst cpu_hold", 32'(cpu_hold), 32'd1);
    checkOutput("midrst done", 32'(done), 32'd0);
    checkOutput("midrst err", 32'(err), 32'd0);
    byte_valid = 1'b1;
    byte_data  = 8'h77;
    repeat (10) @(negedge clk);
    byte_valid = 1'b0;
    checkOutput("midrst still_idle", 32'(byte_ready), 32'd0);
    checkOutput("midrst write_count", 32'(log_addr.size() - base), 32'd1);
    if (log_data.size() > base)
      checkOutput("midrst word0", log_data[base], 32'hf8000001);
  endtask

  initial begin
    applyStimulus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
